// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill engine.
// Captures a missing address with its two-way set, fetches one word from
// memory, and returns the rebuilt set to the cache as a single-cycle write.
module icache_refill_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         miss_valid,
  input  logic [31:0]  miss_addr,
  input  logic [108:0] miss_line,
  input  logic         flush,
  input  logic         mem_req_ready,
  input  logic         mem_rsp_valid,
  input  logic [31:0]  mem_rsp_data,
  output logic         mem_req_valid,
  output logic [31:0]  mem_req_addr,
  output logic         line_wr_valid,
  output logic [31:0]  line_wr_addr,
  output logic [108:0] line_wr_data,
  output logic         busy,
  output logic         fill_err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   addr_q;
  logic [108:0]  line_q;
  logic [31:0]   rsp_q;
  logic [7:0]    cnt;
  logic          discard;
  logic          expired;

  // Rebuild the set: the victim way gets the new tag/data and becomes valid,
  // victim_ptr points at the other way, reserved bits are forced to zero.
  // Victim: an invalid way0 first, then an invalid way1, else victim_ptr.
  function automatic logic [108:0] fill_line(input logic [108:0] line,
                                             input logic [31:0]  addr,
                                             input logic [31:0]  data);
    logic         way1_sel;
    logic [108:0] res;
    way1_sel       = line[53] & (~line[108] | line[52]);
    res            = line;
    res[107:106]   = 2'b00;
    if (way1_sel) begin
      res[108]     = 1'b1;
      res[105:86]  = addr[31:12];
      res[85:54]   = data;
      res[52]      = 1'b0;
    end else begin
      res[53]      = 1'b1;
      res[51:32]   = addr[31:12];
      res[31:0]    = data;
      res[52]      = 1'b1;
    end
    return res;
  endfunction

  assign expired = (cnt == TMO);

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a response in the expiry cycle takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss_valid && !flush) state_nxt = S_REQ;
      S_REQ: begin
        if (mem_req_ready)  state_nxt = S_WAIT;
        else if (flush)     state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rsp_valid)  state_nxt = (discard || flush) ? S_IDLE : S_WRITE;
        else if (expired)   state_nxt = S_IDLE;
      end
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture registers, wait counter and discard flag
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q  <= '0;
      line_q  <= '0;
      rsp_q   <= '0;
      cnt     <= '0;
      discard <= 1'b0;
    end else begin
      if (state == S_IDLE && miss_valid && !flush) begin
        addr_q <= miss_addr;
        line_q <= miss_line;
      end
      case (state)
        S_REQ: begin
          if (mem_req_ready) begin
            cnt     <= '0;
            discard <= flush;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_q   <= mem_rsp_data;
            discard <= 1'b0;
          end else if (expired) begin
            discard <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
            if (flush) discard <= 1'b1;
          end
        end
        default: discard <= 1'b0;
      endcase
    end
  end

  // Outputs decoded from state; data buses are zero outside their strobe
  always_comb begin
    mem_req_valid = (state == S_REQ);
    mem_req_addr  = (state == S_REQ) ? {addr_q[31:2], 2'b00} : '0;
    line_wr_valid = (state == S_WRITE);
    line_wr_addr  = (state == S_WRITE) ? addr_q : '0;
    line_wr_data  = (state == S_WRITE) ? fill_line(line_q, addr_q, rsp_q) : '0;
    busy          = (state != S_IDLE);
    fill_err      = (state == S_WAIT) && !mem_rsp_valid && expired;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios plus
// randomized transactions against a field-level model of the set update.
module tb_icache_refill_ctrl;

  localparam int TMO = 4;

  logic         clk;
  logic         rst_n;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic [108:0] miss_line;
  logic         flush;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         line_wr_valid;
  logic [31:0]  line_wr_addr;
  logic [108:0] line_wr_data;
  logic         busy;
  logic         fill_err;

  int n_chk  = 0;
  int n_fail = 0;

  icache_refill_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_line     (miss_line),
    .flush         (flush),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .line_wr_valid (line_wr_valid),
    .line_wr_addr  (line_wr_addr),
    .line_wr_data  (line_wr_data),
    .busy          (busy),
    .fill_err      (fill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [108:0] got, input logic [108:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [108:0] rand_line();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[108:0];
  endfunction

  // Set update from the field description: unpack both ways, pick the victim,
  // overwrite its fields, repack with the reserved bits cleared.
  function automatic logic [108:0] model_fill(input logic [108:0] old,
                                              input logic [31:0] addr,
                                              input logic [31:0] data);
    logic        v0, v1, ptr;
    logic [19:0] t0, t1;
    logic [31:0] d0, d1;
    int          victim;
    v1 = old[108]; t1 = old[105:86]; d1 = old[85:54];
    v0 = old[53];  ptr = old[52];    t0 = old[51:32]; d0 = old[31:0];
    if (!v0)      victim = 0;
    else if (!v1) victim = 1;
    else          victim = ptr ? 1 : 0;
    if (victim == 0) begin
      v0 = 1'b1; t0 = addr[31:12]; d0 = data; ptr = 1'b1;
    end else begin
      v1 = 1'b1; t1 = addr[31:12]; d1 = data; ptr = 1'b0;
    end
    return {v1, 2'b00, t1, d1, v0, ptr, t0, d0};
  endfunction

  // mode: 0 normal fill, 1 flush in REQ without ready, 2 flush together with
  // ready, 3 flush in WAIT before the response, 4 no response (timeout).
  task automatic run_txn(input logic [31:0] addr, input logic [108:0] line,
                         input int rdly, input int rsp_at, input int mode,
                         input logic [31:0] data, input logic [108:0] exp_line);
    logic done;
    logic expect_err;
    // capture cycle
    miss_valid = 1'b1; miss_addr = addr; miss_line = line; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("cap_busy", busy, 0);
    chk("cap_req", mem_req_valid, 0);
    next_cycle();
    // request phase; misses presented here must be dropped
    for (int i = 0; i <= rdly; i++) begin
      miss_valid = 1'b1; miss_addr = $urandom; miss_line = rand_line();
      mem_req_ready = (i == rdly);
      flush = (mode == 1 && i == 0) || (mode == 2 && i == rdly);
      @(negedge clk);
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
      chk("req_busy", busy, 1);
      chk("req_wr", line_wr_valid, 0);
      next_cycle();
      if (mode == 1) break;
    end
    mem_req_ready = 1'b0;
    flush = 1'b0;
    if (mode != 1) begin
      done = 1'b0;
      for (int j = 0; j <= TMO && !done; j++) begin
        mem_rsp_valid = (mode != 4 && j == rsp_at);
        mem_rsp_data  = mem_rsp_valid ? data : $urandom;
        flush = (mode == 3 && j == 0);
        expect_err = (mode == 4 && j == TMO);
        @(negedge clk);
        chk("wait_req", mem_req_valid, 0);
        chk("wait_busy", busy, 1);
        chk("wait_wr", line_wr_valid, 0);
        chk("wait_err", fill_err, expect_err);
        done = mem_rsp_valid || expect_err;
        next_cycle();
      end
      mem_rsp_valid = 1'b0;
      flush = 1'b0;
      if (mode == 0) begin
        flush = 1'($urandom_range(0, 1));
        miss_valid = 1'b1; miss_addr = $urandom;
        @(negedge clk);
        chk("wr_valid", line_wr_valid, 1);
        chk("wr_addr", line_wr_addr, addr);
        chk("wr_data", line_wr_data, exp_line);
        chk("wr_busy", busy, 1);
        chk("wr_err", fill_err, 0);
        next_cycle();
      end
    end
    // back in IDLE
    miss_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_wr", line_wr_valid, 0);
    chk("idle_err", fill_err, 0);
    chk("idle_req", mem_req_valid, 0);
    next_cycle();
  endtask

  initial begin
    logic [108:0] line;
    logic [108:0] exp_first;
    logic [31:0]  addr;
    logic [31:0]  data;
    int           mode;
    int           rdly;
    int           rsp_at;

    rst_n = 1'b0;
    miss_valid = 1'b0; miss_addr = '0; miss_line = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_wr", line_wr_valid, 0);
    chk("rst_wr_addr", line_wr_addr, 0);
    chk("rst_wr_data", line_wr_data, 0);
    chk("rst_err", fill_err, 0);
    rst_n = 1'b1;
    next_cycle();

    // empty set, zero-wait memory
    exp_first = {55'd0, 1'b1, 1'b1, 20'h00001, 32'hDEADBEEF};
    run_txn(32'h0000_1234, '0, 0, 0, 0, 32'hDEAD_BEEF, exp_first);

    // both ways valid, victim_ptr selects way1
    line = rand_line();
    line[108] = 1'b1; line[53] = 1'b1; line[52] = 1'b1;
    data = $urandom;
    run_txn(32'h0000_5008, line, 0, 0, 0, data,
            {1'b1, 2'b00, 20'h00005, data, 1'b1, 1'b0, line[51:0]});

    // backpressure: ready after five stalled cycles
    line = rand_line();
    data = $urandom;
    run_txn(32'h1234_5677, line, 5, 0, 0, data, model_fill(line, 32'h1234_5677, data));

    // flush in WAIT, response three cycles later, then a normal miss
    run_txn(32'h0000_2000, rand_line(), 0, 3, 3, $urandom, '0);
    line = rand_line();
    data = $urandom;
    run_txn(32'hABCD_0004, line, 1, 1, 0, data, model_fill(line, 32'hABCD_0004, data));

    // timeout with no response
    run_txn(32'h0000_3000, rand_line(), 0, 0, 4, 0, '0);

    // response in the expiry cycle still completes the fill
    line = rand_line();
    data = $urandom;
    run_txn(32'h0F0F_0F0C, line, 0, TMO, 0, data, model_fill(line, 32'h0F0F_0F0C, data));

    // reset in the middle of WAIT, late response afterwards
    miss_valid = 1'b1; miss_addr = 32'h7777_0000; miss_line = rand_line();
    next_cycle();
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_req", mem_req_valid, 0);
    chk("mrst_wr", line_wr_valid, 0);
    chk("mrst_err", fill_err, 0);
    chk("mrst_data", line_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_busy", busy, 0);
      chk("late_wr", line_wr_valid, 0);
      next_cycle();
      mem_rsp_valid = 1'b0;
    end

    // randomized transactions
    for (int t = 0; t < 250; t++) begin
      addr   = $urandom;
      line   = rand_line();
      data   = $urandom;
      rdly   = $urandom_range(0, 3);
      rsp_at = $urandom_range(0, TMO);
      case ($urandom_range(0, 9))
        6: mode = 1;
        7: mode = 2;
        8: mode = 3;
        9: mode = 4;
        default: mode = 0;
      endcase
      if (mode == 1 && rdly == 0) rdly = 1;
      if (mode == 3 && rsp_at == 0) rsp_at = 1;
      run_txn(addr, line, rdly, rsp_at, mode, data, model_fill(line, addr, data));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-refill engine downstream of the instruction cache compare stage. It captures a miss (address plus the 109-bit set contents read at the compare stage) and issues a single-word read to the memory side. It builds the updated 109-bit set entry and returns it to the cache write port as a one-cycle write pulse, together with the write-valid indication the cache uses to produce its "prepare successfully" response.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waited in WAIT for a memory response before aborting (8-bit counter; legal range 1-255)

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous active-low reset
miss_valid  input  1  cache compare stage reports a miss (registered request_valid)
miss_addr  input  32  missing fetch address
miss_line  input  109  set contents read for miss_addr
flush  input  1  pipeline redirect; abandon the current refill
mem_req_ready  input  1  memory accepts the request this cycle
mem_rsp_valid  input  1  memory read data valid
mem_rsp_data  input  32  memory read data
mem_req_valid  output  1  read request to memory
mem_req_addr  output  32  word-aligned request address
line_wr_valid  output  1  one-cycle write strobe to cache (drives r_memory_valid_input)
line_wr_addr  output  32  address of the set being written
line_wr_data  output  109  new set contents
busy  output  1  high in any state other than IDLE
fill_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: single clock CLK; RESET asynchronous, active-low.
- Set layout:
  - way1 = {valid[108], reserved[107:106]=0, tag[105:86], data[85:54]}
  - way0 = {valid[53], victim_ptr[52], tag[51:32], data[31:0]}
  - tag = addr[31:12]
- Reset state: IDLE. All outputs 0. Capture registers, counter and discard flag cleared.
- States: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - On miss_valid=1 and flush=0, capture miss_addr and miss_line; go to REQ next cycle.
  - miss_valid is ignored in every other state (no queueing).
- REQ:
  - mem_req_valid=1 and mem_req_addr={addr_q[31:2],2'b00}, both held stable until mem_req_ready.
  - flush=1 without ready: go to IDLE, no request issued.
  - ready=1 (regardless of flush): go to WAIT and clear the counter. If flush was also 1, set discard.
- WAIT:
  - Counter increments each cycle without mem_rsp_valid.
  - flush in WAIT sets discard; the state remains WAIT so the outstanding response is still absorbed.
  - mem_rsp_valid=1: latch mem_rsp_data. Go to WRITE if discard=0, else IDLE with discard cleared.
  - If the counter reaches TIMEOUT_CYCLES with no response, pulse fill_err for 1 cycle and go to IDLE; no write. A response arriving in the same cycle as expiry wins.
- Victim selection (computed from the captured line):
  - way0 invalid → way0.
  - Else way1 invalid → way1.
  - Else victim_ptr: 0 = way0, 1 = way1.
- WRITE (exactly 1 cycle): line_wr_valid=1, line_wr_addr=addr_q.
  - line_wr_data = captured line with the victim way replaced by {valid=1, tag=addr_q[31:12], data=rsp}, reserved bits forced to 0.
  - victim_ptr is set to the inverse of the way just written.
  - Non-victim way bits pass through unchanged.
  - Next state is IDLE.
- flush in WRITE: ignored; the write completes.
- Latency with zero-wait memory (ready in REQ, response the next cycle):
  - miss accepted at cycle N; mem_req_valid at N+1; response at N+2; line_wr_valid at N+3; IDLE at N+4.
- busy=1 from the cycle after capture until return to IDLE. A miss_valid presented during busy is dropped; the cache re-requests after its response.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. A late memory response arriving afterwards in IDLE is ignored.

Test Plan:
- Empty-set miss: addr=0x0000_1234, miss_line=0, ready at once, rsp 0xDEAD_BEEF next cycle → write at N+3, addr 0x0000_1234; way0 = valid 1, tag 0x00001, data 0xDEADBEEF; victim_ptr=1; way1 all 0.
- Both ways valid with victim_ptr=1: addr=0x0000_5008 → way1 replaced with tag 0x00005 and rsp data; way0 bits [51:0] unchanged; bit52=0.
- Backpressure: mem_req_ready low 5 cycles → mem_req_valid and addr stable for 6 cycles; write 2 cycles after ready.
- Flush during WAIT, rsp arrives 3 cycles later → no line_wr_valid; IDLE the cycle after the response; next miss accepted normally.
- Timeout with TIMEOUT_CYCLES=4, no response → fill_err pulses once, 4 cycles after entering WAIT; no write; busy falls the next cycle.
- Reset low while in WAIT, then mem_rsp_valid after release → outputs 0 and no write.
